// File: rtl/tdpram_pkg.sv
// Shared write-mode encodings and the byte-merge helper for the tdpram true dual-port RAM.
package tdpram_pkg;

    typedef enum logic [1:0] {
        NO_CHANGE   = 2'd0,
        READ_FIRST  = 2'd1,
        WRITE_FIRST = 2'd2
    } wr_mode_e;

    // Widest word be_merge handles; callers extend operands to this width and cast the result back.
    localparam int MAX_DW = 1024;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0]   old_w,
        input logic [MAX_DW-1:0]   new_w,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] merged;
        merged = old_w;
        for (int i = 0; i < MAX_DW / 8; i++) begin
            if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/tdpram_port.sv
// One access port of tdpram: range check, byte-merged write word and the read-data register
// with the same-port read-during-write mode mux.
module tdpram_port
    import tdpram_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int RAM_Depth  = 16,
    parameter int WR_MODE    = 1,
    parameter int AW         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cs,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_addr,
    input  logic [Data_Width/8-1:0] i_be,
    input  logic [Data_Width-1:0]   i_wdata,
    input  logic [Data_Width-1:0]   i_old,
    output logic                    o_in_range,
    output logic                    o_we,
    output logic [Data_Width-1:0]   o_merged,
    output logic [Data_Width-1:0]   o_rdata,
    output logic                    o_rvalid,
    output logic                    o_err
);
    localparam wr_mode_e MODE = wr_mode_e'(2'(WR_MODE));

    logic [Data_Width-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_err;

    assign o_in_range = {1'b0, i_addr} < (AW+1)'(RAM_Depth);
    assign o_we       = i_cs & i_wr_en & o_in_range;
    assign o_merged   = Data_Width'(be_merge(MAX_DW'(i_old), MAX_DW'(i_wdata), (MAX_DW/8)'(i_be)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= i_cs & ~o_in_range;
            r_rvalid <= 1'b0;
            if (i_cs && !i_wr_en) begin
                // Out-of-range reads still complete, returning zero.
                r_rdata  <= o_in_range ? i_old : '0;
                r_rvalid <= 1'b1;
            end else if (o_we) begin
                if (MODE == READ_FIRST) begin
                    r_rdata  <= i_old;
                    r_rvalid <= 1'b1;
                end else if (MODE == WRITE_FIRST) begin
                    r_rdata  <= o_merged;
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_err    = r_err;

endmodule

// File: rtl/tdpram.sv
// tdpram: true dual-port RAM with byte enables, read-during-write modes and collision counting.
// Define TDPRAM_OUT_REG_EN to add an output register stage (read latency 2).
module tdpram
    import tdpram_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int RAM_Depth  = 16,
    parameter int WR_MODE    = 1,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_cs,
    input  logic                         a_wr_en,
    input  logic [$clog2(RAM_Depth)-1:0] a_addr,
    input  logic [Data_Width/8-1:0]      a_be,
    input  logic [Data_Width-1:0]        a_wdata,
    output logic [Data_Width-1:0]        a_rdata,
    output logic                         a_rvalid,
    output logic                         a_err,
    input  logic                         b_cs,
    input  logic                         b_wr_en,
    input  logic [$clog2(RAM_Depth)-1:0] b_addr,
    input  logic [Data_Width/8-1:0]      b_be,
    input  logic [Data_Width-1:0]        b_wdata,
    output logic [Data_Width-1:0]        b_rdata,
    output logic                         b_rvalid,
    output logic                         b_err,
    output logic                         coll,
    output logic [CNT_W-1:0]             coll_cnt
);
    localparam int AW = $clog2(RAM_Depth);

    logic [Data_Width-1:0] r_mem [RAM_Depth];

    logic [Data_Width-1:0] w_a_old, w_b_old;
    logic [Data_Width-1:0] w_a_merged, w_b_merged, w_b_wword;
    logic [Data_Width-1:0] w_a_rdata, w_b_rdata;
    logic                  w_a_in, w_b_in, w_a_we, w_b_we;
    logic                  w_a_rvalid, w_b_rvalid, w_a_err, w_b_err;
    logic                  w_coll;
    logic                  r_coll;
    logic [CNT_W-1:0]      r_coll_cnt;

    assign w_a_old = r_mem[w_a_in ? a_addr : '0];
    assign w_b_old = r_mem[w_b_in ? b_addr : '0];

    tdpram_port #(
        .Data_Width(Data_Width), .RAM_Depth(RAM_Depth), .WR_MODE(WR_MODE), .AW(AW)
    ) u_port_a (
        .clk(clk), .rst(rst),
        .i_cs(a_cs), .i_wr_en(a_wr_en), .i_addr(a_addr), .i_be(a_be), .i_wdata(a_wdata),
        .i_old(w_a_old), .o_in_range(w_a_in), .o_we(w_a_we), .o_merged(w_a_merged),
        .o_rdata(w_a_rdata), .o_rvalid(w_a_rvalid), .o_err(w_a_err)
    );

    tdpram_port #(
        .Data_Width(Data_Width), .RAM_Depth(RAM_Depth), .WR_MODE(WR_MODE), .AW(AW)
    ) u_port_b (
        .clk(clk), .rst(rst),
        .i_cs(b_cs), .i_wr_en(b_wr_en), .i_addr(b_addr), .i_be(b_be), .i_wdata(b_wdata),
        .i_old(w_b_old), .o_in_range(w_b_in), .o_we(w_b_we), .o_merged(w_b_merged),
        .o_rdata(w_b_rdata), .o_rvalid(w_b_rvalid), .o_err(w_b_err)
    );

    // On a same-address double write, B's word is built on top of A's so A owns its enabled bytes.
    assign w_coll    = w_a_we & w_b_we & (a_addr == b_addr);
    assign w_b_wword = w_coll
        ? Data_Width'(be_merge(MAX_DW'(w_a_merged), MAX_DW'(b_wdata), (MAX_DW/8)'(b_be & ~a_be)))
        : w_b_merged;

    always_ff @(posedge clk) begin
        if (w_a_we) r_mem[a_addr] <= w_a_merged;
        if (w_b_we) r_mem[b_addr] <= w_b_wword;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll && (r_coll_cnt != '1)) r_coll_cnt <= r_coll_cnt + CNT_W'(1);
        end
    end

    assign coll_cnt = r_coll_cnt;

`ifdef TDPRAM_OUT_REG_EN
    logic [Data_Width-1:0] r_a_rdata_q, r_b_rdata_q;
    logic                  r_a_rvalid_q, r_b_rvalid_q, r_a_err_q, r_b_err_q, r_coll_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata_q  <= '0;
            r_b_rdata_q  <= '0;
            r_a_rvalid_q <= 1'b0;
            r_b_rvalid_q <= 1'b0;
            r_a_err_q    <= 1'b0;
            r_b_err_q    <= 1'b0;
            r_coll_q     <= 1'b0;
        end else begin
            r_a_rdata_q  <= w_a_rdata;
            r_b_rdata_q  <= w_b_rdata;
            r_a_rvalid_q <= w_a_rvalid;
            r_b_rvalid_q <= w_b_rvalid;
            r_a_err_q    <= w_a_err;
            r_b_err_q    <= w_b_err;
            r_coll_q     <= r_coll;
        end
    end

    assign a_rdata  = r_a_rdata_q;
    assign b_rdata  = r_b_rdata_q;
    assign a_rvalid = r_a_rvalid_q;
    assign b_rvalid = r_b_rvalid_q;
    assign a_err    = r_a_err_q;
    assign b_err    = r_b_err_q;
    assign coll     = r_coll_q;
`else
    assign a_rdata  = w_a_rdata;
    assign b_rdata  = w_b_rdata;
    assign a_rvalid = w_a_rvalid;
    assign b_rvalid = w_b_rvalid;
    assign a_err    = w_a_err;
    assign b_err    = w_b_err;
    assign coll     = r_coll;
`endif

endmodule

// File: tb/tb_tdpram.sv
// Bench for tdpram: three instances (READ_FIRST, WRITE_FIRST, NO_CHANGE) share one stimulus;
// a reference model pushes expected outputs per cycle and the tests pop and compare them.
module tb_tdpram;

`ifdef TDPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cs, a_wr_en, b_cs, b_wr_en;
    logic [3:0]  a_addr, b_addr, a_be, b_be;
    logic [31:0] a_wdata, b_wdata;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, a_err, b_rvalid, b_err, coll;
    logic [1:0]  coll_cnt;

    logic [31:0] wf_a_rdata, wf_b_rdata, nc_a_rdata, nc_b_rdata;
    logic        wf_a_rvalid, wf_a_err, wf_b_rvalid, wf_b_err, wf_coll;
    logic        nc_a_rvalid, nc_a_err, nc_b_rvalid, nc_b_err, nc_coll;
    logic [7:0]  wf_coll_cnt, nc_coll_cnt;

    always #5 clk = ~clk;

    tdpram #(.Data_Width(32), .RAM_Depth(12), .WR_MODE(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_err(a_err),
        .b_cs(b_cs), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_err(b_err),
        .coll(coll), .coll_cnt(coll_cnt)
    );

    tdpram #(.Data_Width(32), .RAM_Depth(12), .WR_MODE(2), .CNT_W(8)) dut_wf (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(wf_a_rdata), .a_rvalid(wf_a_rvalid), .a_err(wf_a_err),
        .b_cs(b_cs), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(wf_b_rdata), .b_rvalid(wf_b_rvalid), .b_err(wf_b_err),
        .coll(wf_coll), .coll_cnt(wf_coll_cnt)
    );

    tdpram #(.Data_Width(32), .RAM_Depth(12), .WR_MODE(0), .CNT_W(8)) dut_nc (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(nc_a_rdata), .a_rvalid(nc_a_rvalid), .a_err(nc_a_err),
        .b_cs(b_cs), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(nc_b_rdata), .b_rvalid(nc_b_rvalid), .b_err(nc_b_err),
        .coll(nc_coll), .coll_cnt(nc_coll_cnt)
    );

    // a_rd/a_rv indexed by write mode (0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST); B modelled for READ_FIRST.
    typedef struct packed {
        logic [2:0][31:0] a_rd;
        logic [2:0]       a_rv;
        logic             a_er;
        logic [31:0]      b_rd;
        logic             b_rv;
        logic             b_er;
        logic             cl;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        last;
    logic [31:0] mdl [16];
    logic [1:0]  mdl_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic set_a(input logic cs, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        a_cs = cs; a_wr_en = wr; a_addr = addr; a_be = be; a_wdata = data;
    endtask

    task automatic set_b(input logic cs, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        b_cs = cs; b_wr_en = wr; b_addr = addr; b_be = be; b_wdata = data;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        set_b(1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    endtask

    task automatic model_step(output exp_t e);
        logic        a_in, b_in, a_w, b_w;
        logic [31:0] a_old, b_old, a_new;
        a_in  = (a_addr < 4'd12);
        b_in  = (b_addr < 4'd12);
        a_old = a_in ? mdl[a_addr] : 32'h0;
        b_old = b_in ? mdl[b_addr] : 32'h0;
        a_new = a_old;
        for (int i = 0; i < 4; i++) if (a_be[i]) a_new[8*i +: 8] = a_wdata[8*i +: 8];
        a_w = a_cs && a_wr_en && a_in;
        b_w = b_cs && b_wr_en && b_in;
        e      = last;
        e.a_rv = 3'b000;
        e.b_rv = 1'b0;
        e.a_er = a_cs && !a_in;
        e.b_er = b_cs && !b_in;
        e.cl   = a_w && b_w && (a_addr == b_addr);
        if (a_cs && !a_wr_en) begin
            for (int m = 0; m < 3; m++) e.a_rd[m] = a_old;
            e.a_rv = 3'b111;
        end else if (a_w) begin
            e.a_rd[1] = a_old;
            e.a_rd[2] = a_new;
            e.a_rv    = 3'b110;
        end
        if (b_cs && !b_wr_en) begin
            e.b_rd = b_old;
            e.b_rv = 1'b1;
        end else if (b_w) begin
            e.b_rd = b_old;
            e.b_rv = 1'b1;
        end
        if (e.cl && mdl_cnt != 2'd3) mdl_cnt = mdl_cnt + 2'd1;
        // B applied first so A's enabled bytes overwrite it on a collision.
        if (b_w) for (int i = 0; i < 4; i++) if (b_be[i]) mdl[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
        if (a_w) for (int i = 0; i < 4; i++) if (a_be[i]) mdl[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
    endtask

    task automatic step();
        exp_t e;
        model_step(e);
        q.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        if (q.size() >= LAT) cur = q.pop_front();
    endtask

    task automatic flush();
        idle();
        for (int i = 0; i < LAT - 1; i++) step();
    endtask

    task automatic model_reset();
        q.delete();
        cur     = '0;
        last    = '0;
        mdl_cnt = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        n_vec++;
        if ({a_rdata, a_rvalid, a_err, b_rdata, b_rvalid, b_err, coll, coll_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%h/%b/%b b=%h/%b/%b coll=%b cnt=%0d, want all 0",
                     a_rdata, a_rvalid, a_err, b_rdata, b_rvalid, b_err, coll, coll_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 6; i++) begin
            set_a(1'b1, 1'b1, 4'(i), 4'hF, 32'h0);
            set_b(1'b1, 1'b1, 4'(i + 6), 4'hF, 32'h0);
            step();
        end
        flush();
    endtask

    task automatic test_write_read();
        set_a(1'b1, 1'b1, 4'd5, 4'hF, 32'h11223344);
        set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        set_a(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        set_b(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
        step();
        flush();
        n_vec++;
        if (b_rdata !== 32'h11223344 || b_rdata !== cur.b_rd) begin
            n_err++; $display("FAIL wr_rd_data: got %h want %h", b_rdata, 32'h11223344);
        end
        n_vec++;
        if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid: got %b want 1", b_rvalid); end
        idle();
        step();
        n_vec++;
        if (b_rvalid !== cur.b_rv) begin
            n_err++; $display("FAIL wr_rd_valid_1cyc: got %b want %b", b_rvalid, cur.b_rv);
        end
    endtask

    task automatic test_byte_enable();
        set_a(1'b1, 1'b1, 4'd2, 4'b0101, 32'hAABBCCDD); set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        set_a(1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'h00BB00DD) begin
            n_err++; $display("FAIL be_merge: got %h want %h", a_rdata, 32'h00BB00DD);
        end
        set_a(1'b1, 1'b1, 4'd2, 4'b0000, 32'hFFFFFFFF);
        step();
        set_a(1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== cur.a_rd[1] || a_rdata !== 32'h00BB00DD) begin
            n_err++; $display("FAIL be_zero: got %h want %h", a_rdata, 32'h00BB00DD);
        end
    endtask

    task automatic test_rdw();
        set_a(1'b1, 1'b1, 4'd4, 4'hF, 32'h5); set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        set_a(1'b1, 1'b1, 4'd4, 4'hF, 32'h9); set_b(1'b1, 1'b0, 4'd4, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (b_rdata !== 32'h5) begin n_err++; $display("FAIL rdw_cross: got %h want %h", b_rdata, 32'h5); end
        n_vec++;
        if (a_rdata !== 32'h5 || a_rvalid !== 1'b1) begin
            n_err++; $display("FAIL rdw_read_first: got %h/%b want %h/1", a_rdata, a_rvalid, 32'h5);
        end
        n_vec++;
        if (wf_a_rdata !== 32'h9 || wf_a_rvalid !== 1'b1) begin
            n_err++; $display("FAIL rdw_write_first: got %h/%b want %h/1", wf_a_rdata, wf_a_rvalid, 32'h9);
        end
        n_vec++;
        if (nc_a_rdata !== cur.a_rd[0] || nc_a_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rdw_no_change: got %h/%b want %h/0", nc_a_rdata, nc_a_rvalid, cur.a_rd[0]);
        end
        set_a(1'b1, 1'b0, 4'd4, 4'h0, 32'h0); set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'h9) begin n_err++; $display("FAIL rdw_after: got %h want %h", a_rdata, 32'h9); end
    endtask

    task automatic test_same_read();
        set_a(1'b1, 1'b0, 4'd5, 4'h0, 32'h0); set_b(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'h11223344 || b_rdata !== 32'h11223344 || coll !== 1'b0) begin
            n_err++; $display("FAIL same_read: got a=%h b=%h coll=%b want %h %h 0",
                              a_rdata, b_rdata, coll, 32'h11223344, 32'h11223344);
        end
    endtask

    task automatic test_collision();
        logic [1:0] want;
        set_a(1'b1, 1'b1, 4'd7, 4'b0011, 32'h01010101); set_b(1'b1, 1'b1, 4'd7, 4'hF, 32'hF2F2F2F2);
        step();
        n_vec++;
        if (coll_cnt !== 2'd1) begin n_err++; $display("FAIL coll_cnt_first: got %0d want 1", coll_cnt); end
        flush();
        n_vec++;
        if (coll !== 1'b1) begin n_err++; $display("FAIL coll_pulse: got %b want 1", coll); end
        idle();
        step();
        n_vec++;
        if (coll !== 1'b0) begin n_err++; $display("FAIL coll_pulse_end: got %b want 0", coll); end
        for (int k = 0; k < 5; k++) begin
            set_a(1'b1, 1'b1, 4'd7, 4'b0011, 32'h01010101); set_b(1'b1, 1'b1, 4'd7, 4'hF, 32'hF2F2F2F2);
            step();
            want = (k + 2 > 3) ? 2'd3 : 2'(k + 2);
            n_vec++;
            if (coll_cnt !== want) begin
                n_err++; $display("FAIL coll_cnt_sat[%0d]: got %0d want %0d", k, coll_cnt, want);
            end
        end
        idle();
        set_a(1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'hF2F20101) begin
            n_err++; $display("FAIL coll_merge: got %h want %h", a_rdata, 32'hF2F20101);
        end
    endtask

    task automatic test_out_of_range();
        set_a(1'b1, 1'b0, 4'd13, 4'h0, 32'h0); set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'h0 || a_rvalid !== 1'b1 || a_err !== 1'b1) begin
            n_err++; $display("FAIL oor_read: got %h/%b/%b want 0/1/1", a_rdata, a_rvalid, a_err);
        end
        idle();
        step();
        n_vec++;
        if (a_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pulse: got %b want 0", a_err); end
        set_a(1'b1, 1'b1, 4'd14, 4'hF, 32'hCAFEF00D);
        step(); flush();
        n_vec++;
        if (a_err !== 1'b1) begin n_err++; $display("FAIL oor_write_err: got %b want 1", a_err); end
        for (int i = 0; i < 6; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
            set_b(1'b1, 1'b0, 4'(i + 6), 4'h0, 32'h0);
            step();
            n_vec++;
            if (a_rdata !== cur.a_rd[1] || b_rdata !== cur.b_rd) begin
                n_err++; $display("FAIL oor_mem_intact[%0d]: got %h %h want %h %h",
                                  i, a_rdata, b_rdata, cur.a_rd[1], cur.b_rd);
            end
        end
        flush();
    endtask

    task automatic test_mid_reset();
        set_a(1'b1, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF); set_b(1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        step();
        set_a(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
        step(); flush();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({a_rdata, a_rvalid, a_err, b_rdata, b_rvalid, b_err, coll, coll_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got a=%h/%b/%b b=%h/%b/%b coll=%b cnt=%0d, want all 0",
                     a_rdata, a_rvalid, a_err, b_rdata, b_rvalid, b_err, coll, coll_cnt);
        end
        idle();
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        set_a(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        step(); flush();
        n_vec++;
        if (a_rdata !== 32'hDEADBEEF || a_rvalid !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_mem: got %h/%b want %h/1", a_rdata, a_rvalid, 32'hDEADBEEF);
        end
    endtask

    task automatic test_random();
        logic       wa, wb;
        logic [3:0] aa, ba;
        for (int k = 0; k < 200; k++) begin
            wa = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            aa = wa ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
            ba = wb ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
            if (k % 5 == 0) ba = 4'(aa % 4'd12);
            set_a($urandom_range(0, 3) != 0, wa, aa, 4'($urandom_range(0, 15)), $urandom());
            set_b($urandom_range(0, 3) != 0, wb, ba, 4'($urandom_range(0, 15)), $urandom());
            step();
            n_vec++;
            if ({a_rdata, a_rvalid, a_err} !== {cur.a_rd[1], cur.a_rv[1], cur.a_er}) begin
                n_err++; $display("FAIL rand_a[%0d]: got %h/%b/%b want %h/%b/%b", k,
                                  a_rdata, a_rvalid, a_err, cur.a_rd[1], cur.a_rv[1], cur.a_er);
            end
            n_vec++;
            if ({b_rdata, b_rvalid, b_err, coll} !== {cur.b_rd, cur.b_rv, cur.b_er, cur.cl}) begin
                n_err++; $display("FAIL rand_b[%0d]: got %h/%b/%b coll=%b want %h/%b/%b coll=%b", k,
                                  b_rdata, b_rvalid, b_err, coll, cur.b_rd, cur.b_rv, cur.b_er, cur.cl);
            end
            n_vec++;
            if (coll_cnt !== mdl_cnt) begin
                n_err++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, coll_cnt, mdl_cnt);
            end
            n_vec++;
            if ({wf_a_rdata, wf_a_rvalid, nc_a_rdata, nc_a_rvalid} !==
                {cur.a_rd[2], cur.a_rv[2], cur.a_rd[0], cur.a_rv[0]}) begin
                n_err++; $display("FAIL rand_modes[%0d]: got wf=%h/%b nc=%h/%b want wf=%h/%b nc=%h/%b", k,
                                  wf_a_rdata, wf_a_rvalid, nc_a_rdata, nc_a_rvalid,
                                  cur.a_rd[2], cur.a_rv[2], cur.a_rd[0], cur.a_rv[0]);
            end
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_same_read();
        test_collision();
        test_out_of_range();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

endmodule
